// File: rtl/tick_period_meter_if.sv
// Bundles the measurement controls and results of the tick period meter.
// The meter itself connects through the slave modport; whatever drives the
// tick and reads back periods uses the master modport.
interface tick_period_meter_if #(
  parameter int unsigned n = 16
) ();

  logic         enable_i;
  logic         tickIn_i;
  logic [n-1:0] periodLimit_i;
  logic [n-1:0] period_o;
  logic         periodValid_o;
  logic         periodOver_o;
  logic         timeout_o;
  logic         busy_o;

  modport master (
    output enable_i,
    output tickIn_i,
    output periodLimit_i,
    input  period_o,
    input  periodValid_o,
    input  periodOver_o,
    input  timeout_o,
    input  busy_o
  );

  modport slave (
    input  enable_i,
    input  tickIn_i,
    input  periodLimit_i,
    output period_o,
    output periodValid_o,
    output periodOver_o,
    output timeout_o,
    output busy_o
  );

endinterface

// File: rtl/tick_period_meter.sv
// Tick period meter: counts clk cycles between consecutive rising edges of a
// tick strobe, reports each interval with a one-cycle valid pulse, flags
// intervals above a programmable limit, and times out when the counter
// saturates without seeing another edge.
module tick_period_meter #(
  parameter int unsigned n = 16
) (
  input logic                 clk,
  input logic                 rst,
  tick_period_meter_if.slave  bus
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [n-1:0] MaxCount = '1;

  state_t       state_q;
  logic [n-1:0] count_q;
  logic         tickDly_q;
  logic [n-1:0] period_q;
  logic         periodValid_q;
  logic         periodOver_q;
  logic         timeout_q;
  logic         busy_q;
  logic         rise;

  // A held-high level counts once; the delayed copy is refreshed even while disabled.
  assign rise = bus.tickIn_i & ~tickDly_q;

  // Tick history register, independent of enable and state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tickDly_q <= 1'b0;
    end else begin
      tickDly_q <= bus.tickIn_i;
    end
  end

  // Measurement FSM: arms on the first edge, then each edge closes one interval and opens the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      period_q      <= '0;
      periodValid_q <= 1'b0;
      periodOver_q  <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      periodValid_q <= 1'b0;
      periodOver_q  <= 1'b0;
      timeout_q     <= 1'b0;
      if (!bus.enable_i) begin
        state_q <= IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            count_q <= '0;
            if (rise) begin
              state_q <= MEASURE;
              count_q <= {{(n-1){1'b0}}, 1'b1};
              busy_q  <= 1'b1;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_q      <= count_q;
              periodValid_q <= 1'b1;
              periodOver_q  <= (count_q > bus.periodLimit_i);
              count_q       <= {{(n-1){1'b0}}, 1'b1};
            end else if (count_q == MaxCount) begin
              timeout_q <= 1'b1;
              count_q   <= '0;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.period_o      = period_q;
  assign bus.periodValid_o = periodValid_q;
  assign bus.periodOver_o  = periodOver_q;
  assign bus.timeout_o     = timeout_q;
  assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Testbench for tick_period_meter. Drives directed and random tick patterns
// and compares every output, every cycle, against a timestamp-based model:
// the model remembers the cycle number of the last accepted edge and derives
// periods and timeouts from elapsed time.
module tb_tick_period_meter;

  localparam int N    = 8;
  localparam int MAXP = (1 << N) - 1;

  logic clk = 1'b0;
  logic rst;

  tick_period_meter_if #(.n(N)) bus ();

  tick_period_meter #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;
  int cycle      = 0;

  bit mPrevTick;
  bit mArmed;
  bit mValid;
  bit mOver;
  bit mTimeout;
  int mLast;
  int mPeriod;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPrevTick = 1'b0;
    mArmed    = 1'b0;
    mValid    = 1'b0;
    mOver     = 1'b0;
    mTimeout  = 1'b0;
    mPeriod   = 0;
    mLast     = 0;
  endtask

  task automatic checkResetState(input string prefix);
    checkOutput({prefix, "_period"}, {24'd0, bus.period_o}, 0);
    checkOutput({prefix, "_valid"},  {31'd0, bus.periodValid_o}, 0);
    checkOutput({prefix, "_over"},   {31'd0, bus.periodOver_o}, 0);
    checkOutput({prefix, "_timeout"},{31'd0, bus.timeout_o}, 0);
    checkOutput({prefix, "_busy"},   {31'd0, bus.busy_o}, 0);
  endtask

  // One clock cycle: drive inputs, advance the model, compare all outputs.
  task automatic applyStimulus(input bit en, input bit tick, input int limit);
    bit rise;
    int elapsed;
    @(negedge clk);
    bus.enable_i      = en;
    bus.tickIn_i      = tick;
    bus.periodLimit_i = limit[N-1:0];
    @(posedge clk);
    cycle++;
    rise      = tick && !mPrevTick;
    mPrevTick = tick;
    mValid    = 1'b0;
    mOver     = 1'b0;
    mTimeout  = 1'b0;
    if (!en) begin
      mArmed = 1'b0;
    end else if (!mArmed) begin
      if (rise) begin
        mArmed = 1'b1;
        mLast  = cycle;
      end
    end else begin
      elapsed = cycle - mLast;
      if (rise) begin
        mPeriod = elapsed;
        mValid  = 1'b1;
        mOver   = (elapsed > (limit % (MAXP + 1)));
        mLast   = cycle;
      end else if (elapsed >= MAXP) begin
        mTimeout = 1'b1;
        mArmed   = 1'b0;
      end
    end
    #1;
    checkOutput("busy",    {31'd0, bus.busy_o}, int'(mArmed));
    checkOutput("valid",   {31'd0, bus.periodValid_o}, int'(mValid));
    checkOutput("over",    {31'd0, bus.periodOver_o}, int'(mOver));
    checkOutput("timeout", {31'd0, bus.timeout_o}, int'(mTimeout));
    checkOutput("period",  {24'd0, bus.period_o}, mPeriod);
  endtask

  // Repeated tick train: each period starts with 'high' cycles of tick_in=1.
  task automatic tickTrain(input int period, input int high, input int edges, input int limit);
    for (int e = 0; e < edges; e++) begin
      for (int p = 0; p < period; p++) begin
        applyStimulus(1'b1, (p < high), limit);
      end
    end
  endtask

  // Assert reset between clock edges, check outputs clear at once, then release.
  task automatic asyncResetMid();
    #2;
    rst = 1'b1;
    #1;
    checkResetState("async");
    @(negedge clk);
    @(negedge clk);
    bus.enable_i = 1'b0;
    bus.tickIn_i = 1'b0;
    rst          = 1'b0;
    modelReset();
  endtask

  initial begin
    int gap;
    int hi;
    int r;
    int lim;

    rst               = 1'b1;
    bus.enable_i      = 1'b0;
    bus.tickIn_i      = 1'b0;
    bus.periodLimit_i = '0;
    modelReset();
    #12;
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] periodic ticks");
    tickTrain(100, 1, 4, 150);

    $display("[TB] limit compare");
    tickTrain(200, 1, 3, 199);
    tickTrain(200, 1, 3, 200);

    $display("[TB] saturation boundary");
    tickTrain(MAXP, 1, 3, MAXP - 1);

    $display("[TB] timeout");
    tickTrain(300, 1, 2, 100);
    tickTrain(MAXP + 1, 1, 2, 100);

    $display("[TB] level and alternating");
    tickTrain(30, 20, 3, 100);
    tickTrain(2, 1, 10, 1);
    tickTrain(3, 2, 6, 2);

    $display("[TB] enable abort");
    tickTrain(40, 1, 2, 100);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 100);
    for (int i = 0; i < 5; i++)  applyStimulus(1'b0, (i >= 2), 100);
    for (int i = 0; i < 4; i++)  applyStimulus(1'b1, 1'b1, 100);
    for (int i = 0; i < 6; i++)  applyStimulus(1'b1, 1'b0, 100);
    tickTrain(40, 1, 3, 30);

    $display("[TB] async reset mid-measurement");
    tickTrain(50, 1, 2, 100);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 100);
    asyncResetMid();
    tickTrain(60, 1, 3, 59);

    $display("[TB] random stimulus");
    while (cycle < 9000) begin
      r = $urandom_range(0, 9);
      if (r < 7)      gap = $urandom_range(2, 60);
      else if (r < 9) gap = $urandom_range(200, 260);
      else            gap = $urandom_range(250, 320);
      hi  = $urandom_range(1, gap - 1);
      lim = $urandom_range(0, MAXP);
      for (int p = 0; p < gap; p++) begin
        applyStimulus(($urandom_range(0, 99) != 0), (p < hi), lim);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
